// File: rtl/divider_ss.sv
// Iterative restoring unsigned divider, one quotient bit per BUSY cycle, valid/ready result hand-off.
// Optional macro DIV_EARLY_EXIT_EN: finish after one BUSY cycle when b==0 or a<b (data-dependent timing).
module divider_ss #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;

    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_early;
    logic             w_last;

    // Partial remainder is kept WIDTH bits wide: it is always < b, and on a
    // borrow the shifted-out top bit is provably zero.
    always_comb begin
        w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_b};
        w_borrow  = w_trial[WIDTH];
        w_rem_nxt = w_borrow ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
    end

`ifdef DIV_EARLY_EXIT_EN
    assign w_early = (r_cnt == '0) && ((r_b == '0) || (r_quo < r_b));
`else
    assign w_early = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || w_early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_b   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_q   <= '0;
            r_r   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_quo <= a;
                        r_b   <= b;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_dbz <= (b == '0);
                    end
                end
                S_BUSY: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Result registers load on the final step so q/r survive the next accept.
                    if (w_last) begin
                        if (w_early) begin
                            r_q <= (r_b == '0) ? '1 : '0;
                            r_r <= r_quo;
                        end else begin
                            r_q <= w_quo_nxt;
                            r_r <= w_rem_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_ss.sv
// Self-checking bench for divider_ss (WIDTH=8): directed literal cases plus randomized traffic
// compared every cycle against a latency/arithmetic reference model.
module tb_divider_ss;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] q;
    logic [7:0] r;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_fail = 0;

    divider_ss #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] xa, input logic [7:0] xb);
`ifdef DIV_EARLY_EXIT_EN
        if (xb == 8'd0 || xa < xb) return 1;
`endif
        return 8;
    endfunction

    // Reference model: 0 idle, 1 computing, 2 result pending.
    int         m_phase = 0;
    int         m_left = 0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [7:0] m_q = '0, m_r = '0;
    logic       m_dbz = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_q = '0;
            m_r = '0;
            m_dbz = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_a = a;
                    m_b = b;
                    m_left = exp_lat(a, b);
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_dbz = (m_b == 8'd0);
                        if (m_b == 8'd0) begin
                            m_q = 8'hFF;
                            m_r = m_a;
                        end else begin
                            m_q = 8'(int'(m_a) / int'(m_b));
                            m_r = 8'(int'(m_a) % int'(m_b));
                        end
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_q", 32'(q), 32'd0);
            chk("rst_r", 32'(r), 32'd0);
            chk("rst_dbz", 32'(div_by_zero), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("q", 32'(q), 32'(m_q));
            chk("r", 32'(r), 32'(m_r));
            if (m_phase == 2) chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    // Launch one operation from idle; check latency and literal results.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input int eq, input int er,
                         input int edbz, input bit hold, input string nm);
        int n;
        out_ready = ~hold;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 20);
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat(xa, xb)));
        chk({nm, "_q"}, 32'(q), 32'(eq));
        chk({nm, "_r"}, 32'(r), 32'(er));
        chk({nm, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        if (!hold) begin
            @(posedge clk); #1;
            chk({nm, "_idle_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("t0_in_ready", 32'(in_ready), 32'd1);
        chk("t0_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'd100, 8'd7, 14, 2, 0, 1'b0, "div100_7");
        do_op(8'd255, 8'd1, 255, 0, 0, 1'b0, "div255_1");
        do_op(8'd0, 8'd9, 0, 0, 0, 1'b0, "div0_9");
        do_op(8'd5, 8'd0, 255, 5, 1, 1'b0, "div5_0");
        do_op(8'd3, 8'd200, 0, 3, 0, 1'b0, "div3_200");

        do_op(8'd200, 8'd9, 22, 2, 0, 1'b1, "hold");
        repeat (5) begin
            a = 8'd1;
            b = 8'd1;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_q", 32'(q), 32'd22);
            chk("hold_r", 32'(r), 32'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_q_kept", 32'(q), 32'd22);

        a = 8'd200;
        b = 8'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_r", 32'(r), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'd77, 8'd6, 12, 5, 0, 1'b0, "div77_6");

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: b = 8'd0;
                1: b = 8'($urandom_range(1, 15));
                default: b = 8'($urandom);
            endcase
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
